// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the FSM state encodings, the default starvation limit and the
// packed type used to latch one memory request.
package mem_arb_pkg;

  localparam logic [1:0] CIRNO_MA_IDLE = 2'd0;
  localparam logic [1:0] CIRNO_MA_REQ  = 2'd1;
  localparam logic [1:0] CIRNO_MA_RSP  = 2'd2;

  localparam int unsigned CIRNO_STARVE_MAX = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic        ren;
  } mem_req_t;

endpackage

// File: rtl/ma_arb.sv
// Winner select between load/store and fetch, plus the fetch starvation
// counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   idle            arbiter may grant this cycle (FSM idle, not in reset)
//   ls_val, if_val  request valids from load/store and fetch
//   ls_rdy, if_rdy  ready toward the winner; never both high
module ma_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = CIRNO_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ls_val,
  input  logic if_val,
  output logic ls_rdy,
  output logic if_rdy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve;
  logic          starved;

  // Load/store normally wins; fetch takes over once it has been passed
  // over STARVE_MAX times in a row while waiting.
  always_comb begin
    starved = (starve == CW'(STARVE_MAX)) && if_val;
    ls_rdy  = idle && ls_val && !starved;
    if_rdy  = idle && if_val && !(ls_val && !starved);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (if_rdy) begin
      starve <= '0;
    end else if (ls_rdy && if_val && (starve != CW'(STARVE_MAX))) begin
      starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: load/store and instruction fetch share a
// single memory port with at most one transaction outstanding.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   hs_ls4ma_val / hs_ma4ls_rdy    load/store request handshake
//   i_ls_adr/wdat/wen/ren          load/store request fields
//   o_ls_rdat, o_ls_rsp            load/store return data and completion pulse
//   hs_if4ma_val / hs_ma4if_rdy    fetch request handshake
//   i_if_adr                       fetch address
//   o_if_rdat, o_if_rsp            fetch return data and completion pulse
//   hs_ma4mem_val / hs_mem4ma_rdy  memory request handshake
//   o_mem_adr/wdat/wen/ren         registered memory request fields
//   i_mem_rdat, i_mem_rsp          memory response data and strobe
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = CIRNO_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ls4ma_val,
  output logic        hs_ma4ls_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_rsp,
  input  logic        hs_if4ma_val,
  output logic        hs_ma4if_rdy,
  input  logic [31:0] i_if_adr,
  output logic [31:0] o_if_rdat,
  output logic        o_if_rsp,
  output logic        hs_ma4mem_val,
  input  logic        hs_mem4ma_rdy,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_wdat,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rdat,
  input  logic        i_mem_rsp
);

  logic [1:0] state;
  logic       own_if;
  mem_req_t   req;
  logic       idle;
  logic       ls_grant;
  logic       if_grant;

  // Ready and memory valid are gated by rst so every output reads 0
  // throughout reset.
  assign idle          = (state == CIRNO_MA_IDLE) && !rst;
  assign ls_grant      = hs_ls4ma_val && hs_ma4ls_rdy;
  assign if_grant      = hs_if4ma_val && hs_ma4if_rdy;
  assign hs_ma4mem_val = (state == CIRNO_MA_REQ) && !rst;

  assign o_mem_adr  = req.adr;
  assign o_mem_wdat = req.wdat;
  assign o_mem_wen  = req.wen;
  assign o_mem_ren  = req.ren;

  ma_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .ls_val (hs_ls4ma_val),
    .if_val (hs_if4ma_val),
    .ls_rdy (hs_ma4ls_rdy),
    .if_rdy (hs_ma4if_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CIRNO_MA_IDLE;
      own_if    <= 1'b0;
      req       <= '0;
      o_ls_rdat <= '0;
      o_if_rdat <= '0;
      o_ls_rsp  <= 1'b0;
      o_if_rsp  <= 1'b0;
    end else begin
      o_ls_rsp <= 1'b0;
      o_if_rsp <= 1'b0;
      case (state)
        CIRNO_MA_IDLE: begin
          if (ls_grant) begin
            req    <= '{adr: i_ls_adr, wdat: i_ls_wdat, wen: i_ls_wen, ren: i_ls_ren};
            own_if <= 1'b0;
            state  <= CIRNO_MA_REQ;
          end else if (if_grant) begin
            req    <= '{adr: i_if_adr, wdat: '0, wen: '0, ren: 1'b1};
            own_if <= 1'b1;
            state  <= CIRNO_MA_REQ;
          end
        end
        CIRNO_MA_REQ: begin
          // A response strobe arriving here is ignored, even alongside rdy.
          if (hs_mem4ma_rdy) begin
            state <= CIRNO_MA_RSP;
          end
        end
        CIRNO_MA_RSP: begin
          if (i_mem_rsp) begin
            if (own_if) begin
              o_if_rdat <= i_mem_rdat;
              o_if_rsp  <= 1'b1;
            end else begin
              o_ls_rdat <= i_mem_rdat;
              o_ls_rsp  <= 1'b1;
            end
            state <= CIRNO_MA_IDLE;
          end
        end
        default: state <= CIRNO_MA_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive load/store grants while fetch waits.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 hs_ls4ma_val  input  1  load/store request valid (from AGU).
REQ-005 hs_ma4ls_rdy  output  1  load/store request accepted when high with val.
REQ-006 i_ls_adr  input  32  load/store byte address.
REQ-007 i_ls_wdat  input  32  store data, lane-aligned.
REQ-008 i_ls_wen  input  4  store byte enables.
REQ-009 i_ls_ren  input  1  load enable.
REQ-010 o_ls_rdat  output  32  load return data.
REQ-011 o_ls_rsp  output  1  one-cycle pulse: load/store complete, o_ls_rdat valid.
REQ-012 hs_if4ma_val  input  1  fetch request valid.
REQ-013 hs_ma4if_rdy  output  1  fetch request accepted.
REQ-014 i_if_adr  input  32  fetch address.
REQ-015 o_if_rdat  output  32  fetched word.
REQ-016 o_if_rsp  output  1  one-cycle pulse: fetch complete, o_if_rdat valid.
REQ-017 hs_ma4mem_val  output  1  memory request valid.
REQ-018 hs_mem4ma_rdy  input  1  memory accepts request.
REQ-019 o_mem_adr / o_mem_wdat  output  32 each  registered request address and write data.
REQ-020 o_mem_wen  output  4;  o_mem_ren  output  1  registered byte enables and read enable; fetch drives wen=0, ren=1.
REQ-021 i_mem_rdat  input  32;  i_mem_rsp  input  1  response data and one-cycle completion strobe.

Function
REQ-022 FSM states IDLE, REQ, RSP; at most one outstanding memory transaction.
REQ-023 Ready outputs SHALL be high only in IDLE, only toward the current arbitration winner; never both high in the same cycle.
REQ-024 Arbitration in IDLE: load/store wins over fetch, unless starve count == STARVE_MAX and hs_if4ma_val=1, in which case fetch wins.
REQ-025 Starve count: +1 (saturating at STARVE_MAX) on each load/store grant while hs_if4ma_val=1; cleared on any fetch grant; unchanged otherwise.
REQ-026 Grant (val&rdy in IDLE, cycle N): latch address/wdat/wen/ren and requester id; state -> REQ; hs_ma4mem_val=1 from N+1.
REQ-027 REQ: hold hs_ma4mem_val and all o_mem_* stable until hs_mem4ma_rdy=1; then state -> RSP, hs_ma4mem_val=0 next cycle.
REQ-028 RSP: on i_mem_rsp=1 at cycle M, register i_mem_rdat into the owner's rdat output, pulse owner's rsp at M+1, state -> IDLE at M+1; new grant allowed at M+1.
REQ-029 i_mem_rsp in IDLE or REQ SHALL be ignored; i_mem_rsp and hs_mem4ma_rdy in the same REQ cycle: rsp ignored.
REQ-030 Stores (wen!=0, ren=0) and requests with wen=0, ren=0 SHALL still be issued and return an rsp pulse; o_ls_rdat then undefined-but-stable (holds i_mem_rdat).
REQ-031 o_ls_rdat/o_if_rdat hold last value until the next completion for that requester.
REQ-032 Minimum grant-to-rsp latency: 3 cycles (rdy at N+1, rsp at N+2, pulse at N+3).

Reset
REQ-033 On rst: state IDLE, starve count 0, all outputs 0, latched request cleared; reset mid-transaction abandons the transaction, no rsp pulse issued.
REQ-034 First grant possible in the cycle after rst deasserts.

Structure
REQ-035 State encodings (CIRNO_MA_IDLE/REQ/RSP) and STARVE_MAX default belong in the shared cirno9 define file.
REQ-036 One sub-module, ma_arb: combinational winner select plus starve counter register.

Verification
REQ-037 Lone LS load adr=0x100, mem rdy immediate, rsp 1 cycle later with 0xDEADBEEF -> o_ls_rsp pulse at N+3, o_ls_rdat=0xDEADBEEF, o_if_rsp stays 0.
REQ-038 Both val held continuously, STARVE_MAX=4 -> grant sequence LS,LS,LS,LS,IF,LS,...; rdy never simultaneous.
REQ-039 Mem rdy low 5 cycles in REQ -> hs_ma4mem_val and o_mem_adr/wdat/wen stable all 5 cycles; single request issued.
REQ-040 Store wen=4'b0100 wdat=0x00AB0000 -> o_mem_wen=4'b0100, o_mem_ren=0, o_ls_rsp pulses once.
REQ-041 rst asserted during RSP, i_mem_rsp arrives after release -> no rsp pulse, outputs 0, next fetch serviced normally.
REQ-042 Spurious i_mem_rsp in IDLE -> no rsp pulse, rdat outputs unchanged.
